// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------------------------
// program_counter
//
// Fetch-address generator sitting directly after the branch/jump resolver. It issues one
// instruction-memory request per cycle, holds the request stable under memory backpressure,
// parks redirects that cannot be applied immediately, and stops fetching on halt.
//
// Parameters:
//   RESET_VECTOR     first fetch address after reset
//   INCREMENT        sequential step in bytes
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-low reset
//   stall            downstream hazard; no fetch may issue this cycle
//   halt             stop fetching until the next reset
//   shouldUseNewPC   redirect request from the branch resolver
//   branchTo         redirect target (low two bits ignored)
//   fetchReady       instruction memory accepts a request this cycle
//   fetchValid       fetch request valid, address on pcAddress
//   pcAddress        current fetch address
//   linkAddress      pcAddress + 8, link value for JAL/BGEZAL/BLTZAL
//   redirectPending  a captured redirect is waiting to be applied
//   halted           block has stopped fetching
// ---------------------------------------------------------------------------------------------
module program_counter #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] INCREMENT    = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        halt,
    input  logic        shouldUseNewPC,
    input  logic [31:0] branchTo,
    input  logic        fetchReady,
    output logic        fetchValid,
    output logic [31:0] pcAddress,
    output logic [31:0] linkAddress,
    output logic        redirectPending,
    output logic        halted
);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHalted
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        pend_q, pend_d;

    logic [31:0] target_aligned;
    logic        fetch_valid;
    logic        accept;

    // Word-align the redirect target; masking keeps every input bit in use.
    assign target_aligned = branchTo & ~32'h0000_0003;

    assign fetch_valid = (state_q == StRun) && !stall;
    // The edge that takes us into HALTED never counts as a completed fetch.
    assign accept      = fetch_valid && fetchReady && !halt;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        pend_d  = pend_q;

        unique case (state_q)
            StBoot: begin
                if (halt) begin
                    state_d = StHalted;
                    pend_d  = 1'b0;
                end else begin
                    state_d = StRun;
                    // No fetch issues in BOOT, so a redirect here can only be parked.
                    if (shouldUseNewPC) begin
                        tgt_d  = target_aligned;
                        pend_d = 1'b1;
                    end
                end
            end

            StRun: begin
                if (halt) begin
                    // Any redirect in flight is dropped; the address freezes where it is.
                    state_d = StHalted;
                    pend_d  = 1'b0;
                end else if (accept) begin
                    if (shouldUseNewPC) begin
                        pc_d = target_aligned;
                    end else if (pend_q) begin
                        pc_d = tgt_q;
                    end else begin
                        pc_d = pc_q + INCREMENT;
                    end
                    // A fresh redirect supersedes a parked one, so both cases retire it.
                    pend_d = 1'b0;
                end else if (shouldUseNewPC) begin
                    // Request must stay stable; park the target (youngest wins).
                    tgt_d  = target_aligned;
                    pend_d = 1'b1;
                end
            end

            StHalted: begin
                state_d = StHalted;
            end

            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StBoot;
            pc_q    <= RESET_VECTOR;
            tgt_q   <= 32'h0000_0000;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            pend_q  <= pend_d;
        end
    end

    assign fetchValid      = fetch_valid;
    assign pcAddress       = pc_q;
    assign linkAddress     = pc_q + 32'd8;
    assign redirectPending = pend_q;
    assign halted          = (state_q == StHalted);

endmodule

// File: tb/tb_program_counter.sv
// ---------------------------------------------------------------------------------------------
// tb_program_counter
//
// Directed bench for program_counter. A behavioural model tracks the fetch address, parked
// redirect and run mode; a compare process checks every DUT output against it on each falling
// edge. Directed steps additionally pin hand-computed literal values.
// ---------------------------------------------------------------------------------------------
module tb_program_counter;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        halt;
    logic        shouldUseNewPC;
    logic [31:0] branchTo;
    logic        fetchReady;
    logic        fetchValid;
    logic [31:0] pcAddress;
    logic [31:0] linkAddress;
    logic        redirectPending;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    program_counter #(
        .RESET_VECTOR (32'h0000_0000),
        .INCREMENT    (32'd4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .halt            (halt),
        .shouldUseNewPC  (shouldUseNewPC),
        .branchTo        (branchTo),
        .fetchReady      (fetchReady),
        .fetchValid      (fetchValid),
        .pcAddress       (pcAddress),
        .linkAddress     (linkAddress),
        .redirectPending (redirectPending),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 = waiting for first clock, 1 = fetching, 2 = stopped
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    bit          m_pend;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0;
            m_pc   = 32'h0;
            m_tgt  = 32'h0;
            m_pend = 0;
        end else if (m_mode == 2) begin
            // stays stopped until reset
        end else if (halt) begin
            m_mode = 2;
            m_pend = 0;
        end else begin
            bit fetched;
            fetched = (m_mode == 1) && !stall && fetchReady;
            m_mode  = 1;
            if (fetched) begin
                if (shouldUseNewPC)  m_pc = {branchTo[31:2], 2'b00};
                else if (m_pend)     m_pc = m_tgt;
                else                 m_pc = m_pc + 32'd4;
                m_pend = 0;
            end else if (shouldUseNewPC) begin
                m_tgt  = {branchTo[31:2], 2'b00};
                m_pend = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("model.fetchValid", {31'b0, fetchValid}, {31'b0, (m_mode == 1) && !stall});
        check("model.pcAddress", pcAddress, m_pc);
        check("model.linkAddress", linkAddress, m_pc + 32'd8);
        check("model.redirectPending", {31'b0, redirectPending}, {31'b0, m_pend});
        check("model.halted", {31'b0, halted}, {31'b0, m_mode == 2});
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jump(input logic [31:0] addr);
        shouldUseNewPC = 1'b1;
        branchTo       = addr;
        tick();
        shouldUseNewPC = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        stall          = 1'b0;
        halt           = 1'b0;
        shouldUseNewPC = 1'b0;
        branchTo       = 32'h0;
        fetchReady     = 1'b1;
        #1;
        check("rst.pc", pcAddress, 32'h0);
        check("rst.link", linkAddress, 32'h8);
        check("rst.fv", {31'b0, fetchValid}, 32'h0);
        check("rst.halted", {31'b0, halted}, 32'h0);
        tick();
        tick();
        rst = 1'b1;

        // Boot idle cycle, then sequential fetch.
        check("boot.fv", {31'b0, fetchValid}, 32'h0);
        tick();
        check("seq.pc0", pcAddress, 32'h0);
        check("seq.fv", {31'b0, fetchValid}, 32'h1);
        tick();
        check("seq.pc4", pcAddress, 32'h4);
        check("seq.link4", linkAddress, 32'hC);
        tick();
        check("seq.pc8", pcAddress, 32'h8);
        tick();
        check("seq.pcC", pcAddress, 32'hC);
        tick();
        check("seq.pc10", pcAddress, 32'h10);

        // Immediate redirect with misaligned target.
        jump(32'h0000_0103);
        check("redir.pc", pcAddress, 32'h100);
        tick();
        check("redir.next", pcAddress, 32'h104);

        // Backpressure with two redirects; youngest wins.
        jump(32'h20);
        check("bp.start", pcAddress, 32'h20);
        fetchReady     = 1'b0;
        shouldUseNewPC = 1'b1;
        branchTo       = 32'h200;
        tick();
        check("bp.hold1", pcAddress, 32'h20);
        check("bp.pend1", {31'b0, redirectPending}, 32'h1);
        branchTo = 32'h300;
        tick();
        shouldUseNewPC = 1'b0;
        check("bp.fv", {31'b0, fetchValid}, 32'h1);
        tick();
        check("bp.hold3", pcAddress, 32'h20);
        fetchReady = 1'b1;
        tick();
        check("bp.apply", pcAddress, 32'h300);
        check("bp.clear", {31'b0, redirectPending}, 32'h0);

        // Address wrap.
        jump(32'hFFFF_FFFC);
        check("wrap.link_hi", linkAddress, 32'h4);
        tick();
        check("wrap.pc", pcAddress, 32'h0);
        check("wrap.link", linkAddress, 32'h8);

        // Stall for two cycles.
        jump(32'h40);
        stall = 1'b1;
        #1;
        check("stall.fv", {31'b0, fetchValid}, 32'h0);
        tick();
        tick();
        check("stall.pc", pcAddress, 32'h40);
        stall = 1'b0;
        #1;
        check("stall.rel_fv", {31'b0, fetchValid}, 32'h1);
        tick();
        check("stall.next", pcAddress, 32'h44);

        // New redirect outranks a parked one on the same accept.
        stall          = 1'b1;
        shouldUseNewPC = 1'b1;
        branchTo       = 32'h700;
        tick();
        stall    = 1'b0;
        branchTo = 32'h804;
        tick();
        shouldUseNewPC = 1'b0;
        check("prio.pc", pcAddress, 32'h804);
        check("prio.pend", {31'b0, redirectPending}, 32'h0);

        // Halt with simultaneous redirect.
        jump(32'h60);
        halt           = 1'b1;
        shouldUseNewPC = 1'b1;
        branchTo       = 32'h500;
        tick();
        halt           = 1'b0;
        shouldUseNewPC = 1'b0;
        check("halt.halted", {31'b0, halted}, 32'h1);
        check("halt.fv", {31'b0, fetchValid}, 32'h0);
        check("halt.pc", pcAddress, 32'h60);
        check("halt.pend", {31'b0, redirectPending}, 32'h0);
        tick();
        tick();
        check("halt.sticky", {31'b0, halted}, 32'h1);

        // Asynchronous reset mid-cycle.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst.pc", pcAddress, 32'h0);
        check("arst.halted", {31'b0, halted}, 32'h0);
        tick();

        // Halt during boot goes straight to halted.
        rst  = 1'b1;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("boothalt.halted", {31'b0, halted}, 32'h1);
        check("boothalt.pc", pcAddress, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Program counter stage directly downstream of the branch/jump resolver; consumes its redirect request (shouldUseNewPC, branchTo).
- Drives the fetch address and request to instruction memory; feeds pcAddress back to the resolver for offset and jump-region arithmetic.
- Handles memory backpressure, pipeline stalls, redirects that arrive while a fetch cannot issue, and a halt.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
INCREMENT, 4, sequential step in bytes

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  downstream hazard; no fetch may issue this cycle
halt  in  1  stop fetching until next reset
shouldUseNewPC  in  1  redirect request from the branch resolver
branchTo  in  32  redirect target; valid only when shouldUseNewPC=1
fetchReady  in  1  instruction memory accepts a request this cycle
fetchValid  out  1  fetch request valid; address on pcAddress
pcAddress  out  32  current fetch address
linkAddress  out  32  pcAddress + 8; link value for JAL/BGEZAL/BLTZAL
redirectPending  out  1  a captured redirect is waiting to be applied
halted  out  1  block is in HALTED

Behaviour:
- Reset is asynchronous, active-low, and applies at any time, including mid-fetch or mid-redirect. While rst=0:
  - pcAddress=RESET_VECTOR, linkAddress=RESET_VECTOR+8.
  - fetchValid=0, redirectPending=0, halted=0.
  - The pending-target register is 0. State is BOOT.
- States:
  - BOOT: fetchValid=0; goes to RUN on the first clock after reset release. Gives exactly one idle cycle.
  - RUN: fetchValid = !stall.
  - HALTED: fetchValid=0, halted=1. Exited only by reset.
- Accept: fetchValid && fetchReady at a rising edge. On accept, pcAddress updates using this priority:
  1. shouldUseNewPC=1: load {branchTo[31:2],2'b00}.
  2. redirectPending=1: load the pending target, then clear redirectPending.
  3. Otherwise: pcAddress + INCREMENT, modulo 2^32. 0xFFFF_FFFC wraps to 0x0000_0000.
- No accept (stall=1, or fetchReady=0, or fetchValid=0):
  - pcAddress holds.
  - If shouldUseNewPC=1, capture the aligned target into the pending register and set redirectPending=1.
  - A later capture overwrites the earlier one (youngest wins).
- A fetch request stays stable: while fetchValid=1 and fetchReady=0, pcAddress must not change. A redirect is only captured, never applied mid-request.
- Misaligned targets: branchTo[1:0] is always forced to 00.
- linkAddress is combinational from pcAddress (+8, mod 2^32). It updates in the same cycle as pcAddress.
- halt=1 in RUN: enter HALTED next edge. That edge is not an accept, even if fetchReady=1.
  - A simultaneous shouldUseNewPC is dropped; redirectPending clears to 0.
  - pcAddress holds its current value.
- halt in BOOT: takes effect on the transition, so the block goes BOOT→HALTED.
- stall and fetchReady=0 together: same as stall.
- Latency: redirect request to new pcAddress is 1 cycle when accepted in the same cycle. Otherwise it is applied at the first subsequent accept.
- Throughput: one fetch per cycle with fetchReady=1, stall=0.

Test Plan:
- Reset release, RESET_VECTOR=0, fetchReady=1:
  - Cycle 0: fetchValid=0 (BOOT).
  - Then pcAddress steps 0,4,8,0xC on successive cycles; linkAddress=pc+8 each cycle.
- At pcAddress=0x10, shouldUseNewPC=1, branchTo=0x0000_0103, fetchReady=1 → next pcAddress=0x100, following 0x104.
- fetchReady=0 for 3 cycles at pcAddress=0x20; shouldUseNewPC=1, branchTo=0x200 in cycle 1, then branchTo=0x300 in cycle 2:
  - pcAddress holds at 0x20; redirectPending=1; fetchValid=1 throughout.
  - On fetchReady=1: pcAddress=0x300, redirectPending=0.
- pcAddress=0xFFFF_FFFC, fetchReady=1, no redirect → pcAddress=0x0000_0000, linkAddress=0x0000_0008.
- stall=1 for 2 cycles at pcAddress=0x40 → fetchValid=0, pcAddress=0x40; after release, 0x40 is fetched, then 0x44.
- halt=1 with shouldUseNewPC=1, branchTo=0x500 at pcAddress=0x60 → halted=1, fetchValid=0, pcAddress stays 0x60, redirectPending=0. Then rst=0 mid-cycle → immediately pcAddress=RESET_VECTOR, halted=0.
